sd_load_ctrl: RTL

SD_LOAD_CTRL -- requirements
Module: sd_load_ctrl

---
 rtl/sd_load_ctrl_pkg.sv | 28 ++
 rtl/sd_load_ctrl_if.sv | 18 +
 rtl/sd_load_ctrl_fifo.sv | 49 ++++
 rtl/sd_load_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sd_load_ctrl_pkg.sv
// Shared types and constants for the SD image loader.
// State encodings, error codes and default image size live here.
package sd_load_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FOUND,
    S_LOAD,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  localparam logic [31:0] DEF_BIN_SIZE = 32'd4096;
  localparam int          FIFO_DEPTH   = 4;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [31:0] n
  );
    return base + (n << 2);
  endfunction

endpackage

// File: rtl/sd_load_ctrl_if.sv
// Memory write handshake between the loader and the memory port.
// The loader holds addr/data stable while wr_req is high.
interface sd_load_ctrl_if;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack
  );
endinterface

// File: rtl/sd_load_ctrl_fifo.sv
// 4x32 synchronous word FIFO with flush.
// A push into a full FIFO succeeds when a pop happens the same cycle.
module sd_word_fifo
  import sd_load_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [2:0]  count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sd_load_ctrl.sv
// Streams bytes from the SD file reader into memory as 32-bit words.
// Bytes pack little-endian; words queue in a 4-deep FIFO before writing.
module sd_load_ctrl
  import sd_load_ctrl_pkg::*;
#(
  parameter logic [31:0] BIN_SIZE    = DEF_BIN_SIZE,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_700_000
) (
  input  logic          clk27mhz,
  input  logic          reset,
  input  logic          start,
  input  logic          rd_file_found,
  input  logic          rd_outen,
  input  logic [7:0]    rd_outbyte,
  sd_load_ctrl_if.master wr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [31:0]   words_written
);

  localparam logic [31:0] NWORDS =
    (BIN_SIZE >> 2) + {31'd0, |BIN_SIZE[1:0]};

  state_e      state_q, state_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] words_q, words_d;
  logic [23:0] idle_q, idle_d;
  logic        pad_q, pad_d;
  logic [1:0]  ecode_q, ecode_d;

  logic        push, pop, clr;
  logic        f_full, f_empty;
  logic [2:0]  f_count;
  logic [31:0] push_data, head;
  logic        req, accept, last;
  logic [1:0]  lane;

  sd_word_fifo u_fifo (
    .clk_i   (clk27mhz),
    .rst_i   (reset),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  assign req = !f_empty &&
    (state_q == S_LOAD || state_q == S_DRAIN);
  assign pop = req && wr.wr_ack;

  assign lane   = bcnt_q[1:0];
  assign accept = (state_q == S_LOAD) && rd_outen &&
    (bcnt_q < BIN_SIZE);
  assign last   = (bcnt_q + 32'd1 == BIN_SIZE);

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    pack_d    = pack_q;
    words_d   = words_q;
    idle_d    = idle_q;
    pad_d     = 1'b0;
    ecode_d   = ecode_q;
    push      = 1'b0;
    push_data = pack_q;
    clr       = 1'b0;

    if (pop) words_d = words_q + 32'd1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_WAIT_FOUND;
          bcnt_d  = '0;
          pack_d  = '0;
          words_d = '0;
          idle_d  = '0;
          ecode_d = ERR_NONE;
          clr     = 1'b1;
        end
      end
      S_WAIT_FOUND: begin
        if (rd_file_found) begin
          state_d = S_LOAD;
          idle_d  = '0;
        end else if (idle_q + 24'd1 == TIMEOUT_CYC) begin
          state_d = S_ERR;
          ecode_d = ERR_TIMEOUT;
          clr     = 1'b1;
        end else begin
          idle_d = idle_q + 24'd1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          idle_d = '0;
          bcnt_d = bcnt_q + 32'd1;
          if (lane == 2'd0) pack_d = '0;
          pack_d[{lane, 3'b000} +: 8] = rd_outbyte;
          if (lane == 2'd3) begin
            push      = 1'b1;
            push_data = {rd_outbyte, pack_q[23:0]};
            pack_d    = '0;
          end
          if (last) begin
            state_d = S_DRAIN;
            pad_d   = (lane != 2'd3);
          end
        end else if (idle_q + 24'd1 == TIMEOUT_CYC) begin
          state_d = S_ERR;
          ecode_d = ERR_TIMEOUT;
          clr     = 1'b1;
        end else begin
          idle_d = idle_q + 24'd1;
        end
      end
      S_DRAIN: begin
        if (pad_q) push = 1'b1;
        if (!pad_q && f_count == 3'd0 && words_q == NWORDS)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A word arriving at a full FIFO with no pop is lost: abort the load.
    if (push && f_full && !pop) begin
      state_d = S_ERR;
      ecode_d = ERR_OVERFLOW;
      push    = 1'b0;
      clr     = 1'b1;
    end
  end

  always_ff @(posedge clk27mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      pack_q  <= '0;
      words_q <= '0;
      idle_q  <= '0;
      pad_q   <= 1'b0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pack_q  <= pack_d;
      words_q <= words_d;
      idle_q  <= idle_d;
      pad_q   <= pad_d;
      ecode_q <= ecode_d;
    end
  end

  assign wr.wr_req  = req;
  assign wr.wr_addr = word_addr(BASE_ADDR, words_q);
  assign wr.wr_data = req ? head : 32'd0;

  assign busy = (state_q == S_WAIT_FOUND) ||
    (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign err_code      = err ? ecode_q : ERR_NONE;
  assign words_written = words_q;

endmodule
